// File: rtl/red_pitaya_pid_pkg.sv
// Shared constants and helpers for the parametrised PID controller family.
package red_pitaya_pid_pkg;

  // Default widths and fixed-point shifts.
  localparam int DW_DEF  = 14;
  localparam int GW_DEF  = 14;
  localparam int IW_DEF  = 32;
  localparam int PSR_DEF = 12;
  localparam int ISR_DEF = 18;
  localparam int DSR_DEF = 10;

  // Bit positions inside the {lo_clamped, hi_clamped} status word.
  localparam int SAT_HI_BIT = 0;
  localparam int SAT_LO_BIT = 1;

  // Clamp a signed value to the range representable in w bits (w <= 63).
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned        w);
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    hi_lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_lim = -hi_lim - 64'sd1;
    if (v > hi_lim)      return hi_lim;
    else if (v < lo_lim) return lo_lim;
    else                 return v;
  endfunction

endpackage

// File: rtl/red_pitaya_pid_lim_if.sv
// Sample stream and settings bundle for one PID channel.
interface red_pitaya_pid_lim_if #(
  parameter int DW = 14,
  parameter int GW = 14
);
  logic signed [DW-1:0] dat_i;
  logic                 dat_vld_i;
  logic signed [DW-1:0] dat_o;
  logic                 dat_vld_o;
  logic signed [DW-1:0] set_sp_i;
  logic signed [GW-1:0] set_kp_i;
  logic signed [GW-1:0] set_ki_i;
  logic signed [GW-1:0] set_kd_i;
  logic signed [DW-1:0] set_lim_hi_i;
  logic signed [DW-1:0] set_lim_lo_i;
  logic                 set_inv_i;
  logic                 int_rst_i;
  logic                 int_hold_i;
  logic [1:0]           sat_o;
  logic                 int_sat_o;

  // Controller side.
  modport slave (
    input  dat_i, dat_vld_i, set_sp_i, set_kp_i, set_ki_i, set_kd_i,
           set_lim_hi_i, set_lim_lo_i, set_inv_i, int_rst_i, int_hold_i,
    output dat_o, dat_vld_o, sat_o, int_sat_o
  );

  // Register bank / stimulus side.
  modport master (
    output dat_i, dat_vld_i, set_sp_i, set_kp_i, set_ki_i, set_kd_i,
           set_lim_hi_i, set_lim_lo_i, set_inv_i, int_rst_i, int_hold_i,
    input  dat_o, dat_vld_o, sat_o, int_sat_o
  );
endinterface

// File: rtl/red_pitaya_pid_clamp.sv
// Signed two-limit clamp with flags; upper limit wins when limits cross.
module red_pitaya_pid_clamp #(
  parameter int W  = 34,
  parameter int OW = 14
) (
  input  logic signed [W-1:0]  val_i,
  input  logic signed [OW-1:0] hi_i,
  input  logic signed [OW-1:0] lo_i,
  output logic signed [OW-1:0] val_o,
  output logic                 hi_o,
  output logic                 lo_o
);
  logic signed [W-1:0] hi_ext;
  logic signed [W-1:0] lo_ext;

  // Compare at full width, then narrow only the in-range value.
  always_comb begin
    // NOTE: every output gets a default before the ifs so no latch is inferred.
    hi_ext = W'(hi_i);
    lo_ext = W'(lo_i);
    val_o  = OW'(val_i);
    hi_o   = 1'b0;
    lo_o   = 1'b0;
    if (val_i > hi_ext) begin
      val_o = hi_i;
      hi_o  = 1'b1;
    end else if (val_i < lo_ext) begin
      val_o = lo_i;
      lo_o  = 1'b1;
    end
  end
endmodule

// File: rtl/red_pitaya_pid_lim.sv
// Four-stage pipelined PID with output limits, anti-windup and integrator control.
module red_pitaya_pid_lim import red_pitaya_pid_pkg::*; #(
  parameter int DW  = DW_DEF,
  parameter int GW  = GW_DEF,
  parameter int IW  = IW_DEF,
  parameter int PSR = PSR_DEF,
  parameter int ISR = ISR_DEF,
  parameter int DSR = DSR_DEF
) (
  input logic              clk_i,
  input logic              rstn_i,
  red_pitaya_pid_lim_if.slave bus
);
  localparam int EW  = DW + 1;       // error width
  localparam int PW  = DW + GW + 1;  // product width
  localparam int DDW = PW + 1;       // derivative difference width
  localparam int IW1 = IW + 1;       // integrator pre-saturation width
  localparam int SW  = IW + 2;       // output sum width
  localparam logic signed [EW-1:0] ERR_MAX = {1'b0, {DW{1'b1}}};
  localparam logic signed [EW-1:0] ERR_MIN = {1'b1, {DW{1'b0}}};

  // Pipeline state.
  logic                  vld1_d, vld1_q, vld2_d, vld2_q, vld3_d, vld3_q, vld4_d, vld4_q;
  logic signed [EW-1:0]  err_d, err_q;
  logic signed [PW-1:0]  kp_prod_d, kp_prod_q, ki_prod_d, ki_prod_q, kd_prod_d, kd_prod_q;
  logic signed [PW-1:0]  p_d, p_q, kd_prev_d, kd_prev_q;
  logic signed [DDW-1:0] d_d, d_q;
  logic signed [IW-1:0]  integ_d, integ_q;
  logic                  int_sat_d, int_sat_q;
  logic signed [DW-1:0]  dat_d, dat_q;
  logic [1:0]            sat_d, sat_q;

  // Combinational intermediates.
  logic signed [EW-1:0]  err_raw;
  logic signed [DDW-1:0] d_full;
  logic signed [IW1-1:0] int_sum;
  logic signed [63:0]    int_clamped;
  logic                  windup;
  logic signed [IW-1:0]  int_shr;
  logic signed [SW-1:0]  sum;
  logic signed [DW-1:0]  clamp_val;
  logic                  clamp_hi, clamp_lo;

  red_pitaya_pid_clamp #(.W(SW), .OW(DW)) u_clamp (
    .val_i (sum),
    .hi_i  (bus.set_lim_hi_i),
    .lo_i  (bus.set_lim_lo_i),
    .val_o (clamp_val),
    .hi_o  (clamp_hi),
    .lo_o  (clamp_lo)
  );

  // Next-state for all four stages; state only advances on valid samples.
  always_comb begin
    // S1: error, optionally negated with saturation of the one unrepresentable case.
    vld1_d  = bus.dat_vld_i;
    err_raw = EW'(bus.set_sp_i) - EW'(bus.dat_i);
    if (bus.set_inv_i) err_d = (err_raw == ERR_MIN) ? ERR_MAX : -err_raw;
    else               err_d = err_raw;

    // S2: gain products.
    vld2_d    = vld1_q;
    kp_prod_d = PW'(err_q) * PW'(bus.set_kp_i);
    ki_prod_d = PW'(err_q) * PW'(bus.set_ki_i);
    kd_prod_d = PW'(err_q) * PW'(bus.set_kd_i);

    // S3: P, D and integrator; anti-windup looks at the flags of the current output.
    vld3_d      = vld2_q;
    p_d         = p_q;
    d_d         = d_q;
    integ_d     = integ_q;
    kd_prev_d   = kd_prev_q;
    int_sat_d   = int_sat_q;
    d_full      = DDW'(kd_prod_q) - DDW'(kd_prev_q);
    int_sum     = IW1'(integ_q) + IW1'(ki_prod_q);
    int_clamped = sat_to_width(64'(int_sum), IW);
    windup      = (sat_q[SAT_HI_BIT] && !ki_prod_q[PW-1] && (ki_prod_q != '0)) ||
                  (sat_q[SAT_LO_BIT] &&  ki_prod_q[PW-1]);
    if (vld2_q) begin
      p_d       = kp_prod_q >>> PSR;
      d_d       = d_full >>> DSR;
      kd_prev_d = kd_prod_q;
      if (bus.int_rst_i) begin
        integ_d   = '0;
        kd_prev_d = '0;
        int_sat_d = 1'b0;
      end else if (!(bus.int_hold_i || windup)) begin
        integ_d   = IW'(int_clamped);
        int_sat_d = (int_clamped != 64'(int_sum));
      end
    end

    // S4: sum and output limit; output holds between strobes.
    vld4_d  = vld3_q;
    int_shr = integ_q >>> ISR;
    sum     = SW'(p_q) + SW'(int_shr) + SW'(d_q);
    dat_d   = dat_q;
    sat_d   = sat_q;
    if (vld3_q) begin
      dat_d             = clamp_val;
      sat_d[SAT_HI_BIT] = clamp_hi;
      sat_d[SAT_LO_BIT] = clamp_lo;
    end
  end

  // Pipeline registers; reset discards every in-flight sample and all history.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses <= so all stages see pre-edge values of each other.
    if (!rstn_i) begin
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
      vld3_q    <= 1'b0;
      vld4_q    <= 1'b0;
      err_q     <= '0;
      kp_prod_q <= '0;
      ki_prod_q <= '0;
      kd_prod_q <= '0;
      p_q       <= '0;
      d_q       <= '0;
      integ_q   <= '0;
      kd_prev_q <= '0;
      int_sat_q <= 1'b0;
      dat_q     <= '0;
      sat_q     <= '0;
    end else begin
      vld1_q    <= vld1_d;
      vld2_q    <= vld2_d;
      vld3_q    <= vld3_d;
      vld4_q    <= vld4_d;
      err_q     <= err_d;
      kp_prod_q <= kp_prod_d;
      ki_prod_q <= ki_prod_d;
      kd_prod_q <= kd_prod_d;
      p_q       <= p_d;
      d_q       <= d_d;
      integ_q   <= integ_d;
      kd_prev_q <= kd_prev_d;
      int_sat_q <= int_sat_d;
      dat_q     <= dat_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.dat_o     = dat_q;
  assign bus.dat_vld_o = vld4_q;
  assign bus.sat_o     = sat_q;
  assign bus.int_sat_o = int_sat_q;
endmodule

// File: tb/tb_red_pitaya_pid_lim.sv
// Self-checking bench: vector table plus hand-built multi-cycle sequences,
// with a latency-aware scoreboard on the output strobe.
module tb_red_pitaya_pid_lim;
  import red_pitaya_pid_pkg::*;

  localparam int DW = 14;
  localparam int GW = 14;
  localparam int LAT = 4;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  red_pitaya_pid_lim_if #(.DW(DW), .GW(GW)) bus ();

  red_pitaya_pid_lim #(.DW(DW), .GW(GW), .IW(32), .PSR(12), .ISR(18), .DSR(10)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int dat;
    int sat;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    int sp, dat, kp, hi, lo;
    bit inv;
    int e_dat, e_sat;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest expectation and its cycle.
  always @(negedge clk_i) begin
    if (rstn_i && bus.dat_vld_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got strobe with dat_o=%0d, expected none", bus.dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("dat_o", bus.dat_o, mon_e.dat);
        check("sat_o", bus.sat_o, mon_e.sat);
        check("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drive one valid sample at the current negedge and register its expected result.
  task automatic sample(input int sp, input int dat, input int e_dat, input int e_sat);
    bus.set_sp_i  = DW'(sp);
    bus.dat_i     = DW'(dat);
    bus.dat_vld_i = 1'b1;
    exp_q.push_back('{e_dat, e_sat, cyc + LAT});
    @(negedge clk_i);
  endtask

  // Bubbles carry random data that must never reach the controller state.
  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dat_vld_i = 1'b0;
      bus.dat_i     = DW'($urandom);
      @(negedge clk_i);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd);
    bus.set_kp_i = GW'(kp);
    bus.set_ki_i = GW'(ki);
    bus.set_kd_i = GW'(kd);
  endtask

  initial begin
    longint acc;
    int     v;

    vecs[0] = '{1000, 0, 4096, 8191, -8191, 1'b0, 1000, 0};     // P-only
    vecs[1] = '{1000, 0, 4096, 500, -8191, 1'b0, 500, 1};       // upper clamp
    vecs[2] = '{-1000, 0, 4096, 8191, -300, 1'b0, -300, 2};     // lower clamp
    vecs[3] = '{-1000, 0, 4096, 8191, -8191, 1'b0, -1000, 0};   // negative in range
    vecs[4] = '{1000, 0, 4096, 8191, -8191, 1'b1, -1000, 0};    // inverted error
    vecs[5] = '{-1, 0, 1, 8191, -8191, 1'b0, -1, 0};            // arithmetic shift
    vecs[6] = '{0, 0, 4096, -100, 100, 1'b0, -100, 1};          // crossed limits
    vecs[7] = '{-8192, 8191, 4096, 8191, -8191, 1'b1, 8191, 1}; // extreme error, inverted
    vecs[8] = '{3000, -2000, 2048, 8191, -8191, 1'b0, 2500, 0}; // half gain

    bus.dat_i = '0; bus.dat_vld_i = 1'b0; bus.set_sp_i = '0;
    set_gains(0, 0, 0);
    bus.set_lim_hi_i = 14'sd8191; bus.set_lim_lo_i = -14'sd8191;
    bus.set_inv_i = 1'b0; bus.int_rst_i = 1'b0; bus.int_hold_i = 1'b0;

    repeat (3) @(negedge clk_i);
    check("rst_dat_o", bus.dat_o, 0);
    check("rst_dat_vld_o", bus.dat_vld_o, 0);
    check("rst_sat_o", bus.sat_o, 0);
    check("rst_int_sat_o", bus.int_sat_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Single-strobe vectors with ki=kd=0; output must hold after the strobe.
    foreach (vecs[i]) begin
      set_gains(vecs[i].kp, 0, 0);
      bus.set_lim_hi_i = DW'(vecs[i].hi);
      bus.set_lim_lo_i = DW'(vecs[i].lo);
      bus.set_inv_i    = vecs[i].inv;
      sample(vecs[i].sp, vecs[i].dat, vecs[i].e_dat, vecs[i].e_sat);
      bubbles(6);
      check("dat_o_holds", bus.dat_o, vecs[i].e_dat);
    end
    bus.set_inv_i = 1'b0;
    bus.set_lim_hi_i = 14'sd8191; bus.set_lim_lo_i = -14'sd8191;

    // Integrator ramp: 1024*256 = 2^18, one output LSB per sample.
    set_gains(0, 256, 0);
    for (int k = 1; k <= 20; k++) sample(1024, 0, k, 0);
    bubbles(6);
    bus.int_hold_i = 1'b1;
    for (int k = 0; k < 10; k++) sample(1024, 0, 20, 0);
    bubbles(6);
    bus.int_hold_i = 1'b0;
    for (int k = 21; k <= 25; k++) sample(1024, 0, k, 0);
    bubbles(6);
    bus.int_rst_i = 1'b1;
    sample(1024, 0, 0, 0);
    bubbles(6);
    bus.int_rst_i = 1'b0;
    sample(1024, 0, 1, 0);
    bubbles(6);

    // Anti-windup: streaming back-to-back, the hi flag reaches the integrator two
    // samples late, so it settles at 102 and unwinds immediately when err flips.
    bus.int_rst_i = 1'b1;
    sample(1024, 0, 0, 0);
    bubbles(6);
    bus.int_rst_i = 1'b0;
    bus.set_lim_hi_i = 14'sd100;
    for (int k = 1; k <= 110; k++) sample(1024, 0, (k > 100) ? 100 : k, (k > 100) ? 1 : 0);
    for (int j = 1; j <= 10; j++) begin
      v = 102 - j;
      sample(0, 1024, (v > 100) ? 100 : v, (v > 100) ? 1 : 0);
    end
    bubbles(6);
    bus.set_lim_hi_i = 14'sd8191;

    // Integrator saturation at the 32-bit bound: err=16383, ki=8191.
    bus.int_rst_i = 1'b1;
    sample(1024, 0, 0, 0);
    bubbles(6);
    bus.int_rst_i = 1'b0;
    set_gains(0, 8191, 0);
    for (int k = 1; k <= 20; k++) begin
      acc = longint'(k) * 64'sd134193153;
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      sample(8191, -8192, int'(acc >>> 18), 0);
    end
    bubbles(6);
    check("int_sat_set", bus.int_sat_o, 1);
    set_gains(0, -8191, 0);
    acc = 64'sd2147483647 - 64'sd134193153;
    sample(8191, -8192, int'(acc >>> 18), 0);
    bubbles(6);
    check("int_sat_cleared", bus.int_sat_o, 0);
    bus.int_rst_i = 1'b1;
    sample(8191, -8192, 0, 0);
    bubbles(6);
    bus.int_rst_i = 1'b0;

    // Derivative: 1000*1024 >>> 10 gives a single pulse of 1000 on the step.
    set_gains(0, 0, 1024);
    for (int k = 0; k < 3; k++) sample(0, 0, 0, 0);
    sample(0, -1000, 1000, 0);
    for (int k = 0; k < 3; k++) sample(0, -1000, 0, 0);
    bubbles(6);
    sample(0, 0, -1000, 0);     bubbles(3);
    sample(0, 0, 0, 0);         bubbles(3);
    sample(0, -1000, 1000, 0);  bubbles(3);
    sample(0, -1000, 0, 0);     bubbles(3);
    sample(0, -1000, 0, 0);     bubbles(6);

    // Async reset mid-stream: first sample after release sees empty history.
    bus.int_rst_i = 1'b1;
    sample(0, -1000, 0, 0);
    bubbles(6);
    bus.int_rst_i = 1'b0;
    set_gains(0, 256, 1024);
    sample(1024, 0, 1025, 0);
    for (int k = 2; k <= 12; k++) sample(1024, 0, k, 0);
    #2 rstn_i = 1'b0;
    #1;
    check("async_rst_dat_o", bus.dat_o, 0);
    check("async_rst_dat_vld_o", bus.dat_vld_o, 0);
    check("async_rst_sat_o", bus.sat_o, 0);
    exp_q.delete();
    bus.dat_vld_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    sample(1024, 0, 1025, 0);
    for (int k = 2; k <= 5; k++) sample(1024, 0, k, 0);
    bubbles(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/red_pitaya_pid_lim.md
Name: red_pitaya_pid_lim

Overview:
- Parametrised single-channel PID controller. Successor to the fixed 14-bit PID block.
- Adds:
  - configurable data and gain widths;
  - a sample-valid handshake, so it can run at decimated rates;
  - programmable output limits with integrator anti-windup;
  - integrator hold, error inversion and saturation status.
- Instantiated N times inside the MIMO controller wrapper, with settings driven from the system-bus register bank.

Parameters:
DW, 14, data/setpoint/limit width (signed)
GW, 14, gain width for Kp/Ki/Kd (signed)
IW, 32, integrator accumulator width (signed)
PSR, 12, proportional right-shift
ISR, 18, integrator right-shift
DSR, 10, derivative right-shift

Ports:
clk_i  in  1  processing clock
rstn_i  in  1  reset, asynchronous, active-low
dat_i  in  DW  input sample, signed
dat_vld_i  in  1  input sample strobe
dat_o  out  DW  controller output, signed
dat_vld_o  out  1  output strobe
set_sp_i  in  DW  setpoint
set_kp_i  in  GW  Kp
set_ki_i  in  GW  Ki
set_kd_i  in  GW  Kd
set_lim_hi_i  in  DW  upper output limit
set_lim_lo_i  in  DW  lower output limit
set_inv_i  in  1  negate error
int_rst_i  in  1  clear integrator and derivative history
int_hold_i  in  1  freeze integrator
sat_o  out  2  {lo_clamped, hi_clamped} of current dat_o
int_sat_o  out  1  integrator hit IW bound on last update

Behaviour:
- Reset (async assert, sync release): dat_o=0, dat_vld_o=0, sat_o=0, int_sat_o=0. Integrator, derivative history and all pipeline registers/valids are 0.
- Fully pipelined: accepts one sample per cycle. Fixed latency of 4 cycles from dat_vld_i to dat_vld_o.
- dat_vld_i low: the sample is a bubble. No integrator or derivative-history update; the valid propagates as 0.
- S1: err = sp - dat at DW+1 bits; negated when set_inv_i=1. Negating the most-negative value saturates to the max positive value.
- S2: register products err*kp, err*ki, err*kd (DW+GW+1 bits, signed).
- S3, on a valid sample only:
  - p = kp_prod >>> PSR (arithmetic shift).
  - d = (kd_prod - kd_prev) >>> DSR; then kd_prev <= kd_prod.
  - Integrator priority:
    1. int_rst_i: integrator <= 0, kd_prev <= 0.
    2. int_hold_i: integrator unchanged.
    3. Anti-windup: sat_o[0]=1 and ki_prod>0, or sat_o[1]=1 and ki_prod<0 → unchanged.
    4. Otherwise integrator <= sat_IW(integrator + ki_prod).
  - int_sat_o is set when the sat_IW clamp engaged; cleared on the next unclamped valid update.
- S4: sum = p + (integrator >>> ISR) + d, computed at IW+2 bits.
  - Clamp order: sum > lim_hi → lim_hi, sat_o=01; else sum < lim_lo → lim_lo, sat_o=10; else sum, sat_o=00.
  - lim_lo > lim_hi is a legal but degenerate setting; the upper clamp is evaluated first.
  - dat_o, sat_o and dat_vld_o update only on a valid sample; dat_o holds between strobes.
- Settings are sampled at the stage that uses them. No double buffering.
- int_rst_i is level-sensitive: while it is high, every valid sample clears the integrator.
- Reset mid-stream discards all in-flight samples. The first post-reset sample uses kd_prev=0.

Decomposition:
- Package red_pitaya_pid_pkg:
  - default DW/GW/IW/PSR/ISR/DSR constants;
  - a signed saturate-to-width function;
  - sat_o bit-index constants.
- One sub-module: red_pitaya_pid_clamp, a parametrised signed two-limit clamp with flag outputs. It is used in S4 and is reusable by the MIMO sum stage.

Test Plan:
- P-only: sp=1000, dat=0, kp=4096, ki=kd=0, limits ±8191, single strobe → dat_o=1000 with dat_vld_o exactly 4 cycles later, sat_o=00.
- Clamp: as above with lim_hi=500 → dat_o=500, sat_o=01. With sp=-1000 and lim_lo=-300 → dat_o=-300, sat_o=10.
- Integrator ramp: err=1024, ki=256, kp=kd=0, dat_vld_i every cycle → dat_o ramps 1,2,3,… one LSB per sample. int_hold_i=1 for 10 samples → dat_o constant. int_rst_i pulse → dat_o returns to 0.
- Anti-windup: ramp setup with lim_hi=100 → dat_o stops at 100, integrator stops growing within pipeline depth. Then err=-1024 → dat_o drops below 100 on the next outputs, with no recovery delay.
- Derivative: kd=1024, dat steps 0→-1000 with sp=0 → a single output pulse of 1000, then 0. Repeat with dat_vld_i every 4th cycle → same single pulse, timed to the strobes.
- Async reset mid-ramp: assert rstn_i between clock edges → dat_o=0 and dat_vld_o=0 immediately. The first sample after release behaves as the first sample from power-up.
